// File: rtl/act_row_streamer.sv
// act_row_streamer
//   Producer end of the 128-bit packed-activation stream feeding the conv3x3
//   line buffer. Walks a feature map row by row out of feature SRAM (1-cycle
//   read latency) and emits each word as a valid/ready beat tagged with
//   end-of-row and end-of-frame markers. A small skid FIFO absorbs the SRAM
//   latency so a consumer holding ready high gets one beat per cycle.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_w_in/h_in/ic      frame geometry (width, height, channels), latched on start
//   cfg_base_addr         SRAM word address of row 0, latched on start
//   start                 1-cycle pulse, accepted only when idle
//   busy, done            busy while streaming; done pulses once at the end
//   mem_rd_en/addr/data   feature SRAM read port (data valid the cycle after en)
//   act_out_*             output stream: data, valid/ready, last_row, last_frame
//   out_row               row index of the beat currently at the FIFO head
module act_row_streamer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cfg_w_in,
  input  logic [15:0]       cfg_h_in,
  input  logic [15:0]       cfg_ic,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [127:0]      mem_rd_data,
  output logic [127:0]      act_out_data,
  output logic              act_out_valid,
  input  logic              act_out_ready,
  output logic              act_out_last_row,
  output logic              act_out_last_frame,
  output logic [15:0]       out_row
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [127:0] data;
    logic         last_row;
    logic         last_frame;
    logic [15:0]  row;
  } beat_t;

  state_t            state, state_nxt;
  logic [15:0]       h_q, rw_q, word_cnt, row_cnt;
  logic [ADDR_W-1:0] addr_q;

  // Read issued last cycle; its flags ride along until the data lands.
  logic              inflight, if_last_row, if_last_frame;
  logic [15:0]       if_row;

  beat_t             fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     fifo_count;

  // Words per row: ceil(W*IC/64). The +63 is done one bit wider so it cannot
  // overflow the 32-bit product; the result is truncated to 16 bits.
  logic [31:0]       prod_in;
  logic [32:0]       sum_in;
  logic [15:0]       rw_in;
  assign prod_in = {16'b0, cfg_w_in} * {16'b0, cfg_ic};
  assign sum_in  = {1'b0, prod_in} + 33'd63;
  assign rw_in   = 16'(sum_in >> 6);

  logic last_word, last_frame_w, push, pop;
  logic [CW:0] occ;

  assign last_word    = (word_cnt == rw_q - 16'd1);
  assign last_frame_w = last_word && (row_cnt == h_q - 16'd1);
  assign push         = inflight;
  assign pop          = act_out_valid && act_out_ready;

  // Slots already claimed: stored beats plus the read still in flight. A pop
  // this cycle frees a slot, so issuing is allowed even at full occupancy.
  assign occ       = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign mem_rd_en = (state == S_RUN) && ((occ < (CW+1)'(FIFO_DEPTH)) || pop);
  assign mem_rd_addr = addr_q;

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // NOTE: next-state defaults to the current state before the case, so no
  // path leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (cfg_h_in == 16'd0 || rw_in == 16'd0) ? S_DONE : S_RUN;
      S_RUN:   if (mem_rd_en && last_frame_w) state_nxt = S_DRAIN;
      S_DRAIN: if (!inflight && (fifo_count == '0 || (fifo_count == CW'(1) && pop)))
                 state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q           <= '0;
      rw_q          <= '0;
      word_cnt      <= '0;
      row_cnt       <= '0;
      addr_q        <= '0;
      inflight      <= 1'b0;
      if_last_row   <= 1'b0;
      if_last_frame <= 1'b0;
      if_row        <= '0;
    end else begin
      inflight <= mem_rd_en;
      if (mem_rd_en) begin
        if_last_row   <= last_word;
        if_last_frame <= last_frame_w;
        if_row        <= row_cnt;
        // Rows are packed back to back, so a plain increment walks the frame.
        addr_q        <= addr_q + ADDR_W'(1);
        if (last_word) begin
          word_cnt <= '0;
          row_cnt  <= row_cnt + 16'd1;
        end else begin
          word_cnt <= word_cnt + 16'd1;
        end
      end
      if (state == S_IDLE && start) begin
        h_q      <= cfg_h_in;
        rw_q     <= rw_in;
        addr_q   <= cfg_base_addr;
        word_cnt <= '0;
        row_cnt  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; occupancy is tracked by the reset
  // pointers/count and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{data: mem_rd_data, last_row: if_last_row,
                                    last_frame: if_last_frame, row: if_row};
  end

  beat_t head;
  assign head               = fifo_mem[rd_ptr];
  assign act_out_valid      = (fifo_count != '0);
  assign act_out_data       = act_out_valid ? head.data       : '0;
  assign act_out_last_row   = act_out_valid ? head.last_row   : 1'b0;
  assign act_out_last_frame = act_out_valid ? head.last_frame : 1'b0;
  assign out_row            = act_out_valid ? head.row        : '0;

endmodule

// File: tb/tb_act_row_streamer.sv
// tb_act_row_streamer
//   Self-checking bench for act_row_streamer. A behavioural SRAM returns a
//   seeded function of the address; the expected stream for each frame is
//   built as a plain list of (address, data, flags, row) from the frame
//   geometry and compared beat by beat against the handshaken output.
module tb_act_row_streamer;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  cfg_w_in, cfg_h_in, cfg_ic, cfg_base_addr;
  logic         start;
  logic         busy, done;
  logic         mem_rd_en;
  logic [15:0]  mem_rd_addr;
  logic [127:0] mem_rd_data = '0;
  logic [127:0] act_out_data;
  logic         act_out_valid;
  logic         act_out_ready;
  logic         act_out_last_row, act_out_last_frame;
  logic [15:0]  out_row;

  always #5 clk = ~clk;

  act_row_streamer #(.ADDR_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_w_in(cfg_w_in), .cfg_h_in(cfg_h_in), .cfg_ic(cfg_ic),
    .cfg_base_addr(cfg_base_addr), .start(start),
    .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .act_out_data(act_out_data), .act_out_valid(act_out_valid),
    .act_out_ready(act_out_ready), .act_out_last_row(act_out_last_row),
    .act_out_last_frame(act_out_last_frame), .out_row(out_row)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] word_of(input logic [15:0] a, input logic [15:0] s);
    return {a, s, a ^ s, ~a, a + s, s - a, {a[7:0], a[15:8]}, a ^ 16'h5a5a};
  endfunction

  // Behavioural SRAM, 1-cycle latency. Data keeps arriving regardless of the
  // DUT reset, which is what makes stale returns observable.
  logic [15:0] sram_seed = 16'h0;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= word_of(mem_rd_addr, sram_seed);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    logic         lr;
    logic         lf;
    logic [15:0]  row;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] exp_addr_q[$];
  int          hs_cyc_q[$];
  int          done_cyc_q[$];

  int          ready_mode = 0;
  int          stall_from = 0;

  initial begin
    act_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       act_out_ready = 1'b1;
        1:       act_out_ready = 1'(cyc % 2);
        2:       act_out_ready = 1'($urandom_range(0, 1));
        default: act_out_ready = !(cyc >= stall_from && cyc < stall_from + 20);
      endcase
    end
  end

  // Output / read-port monitor, sampled on the falling edge.
  int           issued = 0, popped = 0, max_occ = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [17:0]  prev_tag;

  always @(negedge clk) begin : mon
    beat_t b;
    if (!rst_n) begin
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) check("extra_read", 128'(1), 128'(0));
        else check("rd_addr", 128'(mem_rd_addr), 128'(exp_addr_q.pop_front()));
        issued++;
      end
      if (prev_stall) begin
        check("stall_valid", 128'(act_out_valid), 128'(1));
        check("stall_data", act_out_data, prev_data);
        check("stall_tag", 128'({act_out_last_row, act_out_last_frame, out_row}), 128'(prev_tag));
      end
      if (act_out_valid && act_out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 128'(1), 128'(0));
        else begin
          b = exp_q.pop_front();
          check("beat_data", act_out_data, b.data);
          check("beat_flags", 128'({act_out_last_row, act_out_last_frame}), 128'({b.lr, b.lf}));
          check("beat_row", 128'(out_row), 128'(b.row));
        end
        popped++;
        hs_cyc_q.push_back(cyc);
      end
      prev_stall = act_out_valid && !act_out_ready;
      prev_data  = act_out_data;
      prev_tag   = {act_out_last_row, act_out_last_frame, out_row};
      if (issued - popped > max_occ) max_occ = issued - popped;
      if (done) begin
        check("done_busy", 128'(busy), 128'(0));
        done_cyc_q.push_back(cyc);
      end
    end
  end

  // Build the expected frame from geometry alone; returns words per row.
  task automatic load_expect(input int w, input int ic, input int h,
                             input logic [15:0] base, output int rw);
    beat_t       b;
    logic [15:0] a;
    rw = int'(((longint'(w) * longint'(ic) + 63) / 64) & 64'hffff);
    sram_seed = 16'($urandom);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < rw; x++) begin
        a      = base + 16'(y * rw + x);
        b.data = word_of(a, sram_seed);
        b.lr   = (x == rw - 1);
        b.lf   = (x == rw - 1) && (y == h - 1);
        b.row  = 16'(y);
        exp_addr_q.push_back(a);
        exp_q.push_back(b);
      end
    cfg_w_in      = 16'(w);
    cfg_ic        = 16'(ic);
    cfg_h_in      = 16'(h);
    cfg_base_addr = base;
  endtask

  task automatic run_frame(input int w, input int ic, input int h,
                           input logic [15:0] base, input int mode, input bit poke);
    int rw, snap_hs, snap_done, n, beats, start_c, dc;
    @(posedge clk); #1;
    load_expect(w, ic, h, base, rw);
    snap_hs    = hs_cyc_q.size();
    snap_done  = done_cyc_q.size();
    ready_mode = mode;
    start_c    = cyc;
    stall_from = cyc + 6;
    start      = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      start = poke && (n == 3 || n == 4);
      n++;
    end while (done_cyc_q.size() == snap_done && n < 4000);
    start = 1'b0;
    check("done_seen", 128'(done_cyc_q.size() > snap_done), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    beats = hs_cyc_q.size() - snap_hs;
    check("beat_count", 128'(beats), 128'(h * rw));
    check("exp_left", 128'(exp_q.size() + exp_addr_q.size()), 128'(0));
    check("done_pulses", 128'(done_cyc_q.size() - snap_done), 128'(1));
    if (done_cyc_q.size() > snap_done) begin
      dc = done_cyc_q[snap_done];
      if (beats > 0) check("done_time", 128'(dc), 128'(hs_cyc_q[hs_cyc_q.size() - 1] + 1));
      else           check("done_time", 128'(dc), 128'(start_c + 1));
    end
    if (mode == 0 && beats > 0)
      check("throughput", 128'(hs_cyc_q[hs_cyc_q.size() - 1] - hs_cyc_q[snap_hs]), 128'(beats - 1));
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(act_out_valid), 128'(0));
    check({tag, "_busy_done_rd"}, 128'({busy, done, mem_rd_en}), 128'(0));
    check({tag, "_addr"}, 128'(mem_rd_addr), 128'(0));
    check({tag, "_data"}, act_out_data, 128'(0));
    check({tag, "_tag"}, 128'({act_out_last_row, act_out_last_frame, out_row}), 128'(0));
  endtask

  task automatic reset_mid_frame();
    int rw;
    @(posedge clk); #1;
    load_expect(8, 32, 3, 16'h1000, rw);
    ready_mode = 0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_rd", 128'(mem_rd_en), 128'(1));
    rst_n = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_w_in = '0; cfg_h_in = '0; cfg_ic = '0; cfg_base_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_frame(4, 16, 3, 16'h0100, 0, 1'b0);   // row_words=1
    run_frame(8, 32, 2, 16'h0200, 1, 1'b0);   // row_words=4, ready toggling
    run_frame(16, 64, 2, 16'h0300, 3, 1'b0);  // 20-cycle stall mid-frame
    run_frame(5, 16, 0, 16'h0400, 0, 1'b0);   // H=0
    run_frame(0, 16, 2, 16'h0480, 0, 1'b0);   // row_words=0
    reset_mid_frame();
    run_frame(8, 32, 2, 16'h2000, 0, 1'b0);   // restart after abort
    run_frame(8, 32, 2, 16'h0500, 0, 1'b1);   // start pulsed while busy
    run_frame(3, 7, 3, 16'hfffe, 2, 1'b0);    // address wrap, partial word rows

    for (int i = 0; i < 8; i++)
      run_frame(int'($urandom_range(1, 24)), int'($urandom_range(1, 80)),
                int'($urandom_range(0, 4)), 16'($urandom),
                int'($urandom_range(0, 2)), 1'b0);

    check("max_outstanding_le", 128'(max_occ <= DEPTH), 128'(1));
    check("max_outstanding_hit", 128'(max_occ), 128'(DEPTH));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
